mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_pkg.sv | 17 +
 rtl/mem_bus_arbiter_if.sv | 38 +++
 rtl/mem_bus_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared encodings and widths for the memory bus arbiter
package mem_bus_arbiter_pkg;

    localparam int BLOCK_W = 128;
    localparam int BADDR_W = 28;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - cache request ports and shared main-memory port of the arbiter
interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    logic               I_READ;
    logic [BADDR_W-1:0] I_ADDRESS;
    logic [BLOCK_W-1:0] I_READDATA;
    logic               I_BUSYWAIT;

    logic               D_READ;
    logic               D_WRITE;
    logic [BADDR_W-1:0] D_ADDRESS;
    logic [BLOCK_W-1:0] D_WRITEDATA;
    logic [BLOCK_W-1:0] D_READDATA;
    logic               D_BUSYWAIT;

    logic               MEM_READ;
    logic               MEM_WRITE;
    logic [BADDR_W-1:0] MEM_ADDRESS;
    logic [BLOCK_W-1:0] MEM_WRITEDATA;
    logic [BLOCK_W-1:0] MEM_READDATA;
    logic               MEM_BUSYWAIT;

    modport slave (
        input  I_READ, I_ADDRESS, D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
               MEM_READDATA, MEM_BUSYWAIT,
        output I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
               MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );

    modport master (
        output I_READ, I_ADDRESS, D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
               MEM_READDATA, MEM_BUSYWAIT,
        input  I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
               MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );

endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one main-memory port between I and D caches
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    mem_bus_arbiter_if.slave bus
);

    arb_state_t         state, state_nxt;
    logic               last_grant;
    logic               first_cycle;
    logic               i_pend, d_pend, any_pend, winner, granted, done;
    logic               lat_read, lat_write;
    logic [BADDR_W-1:0] lat_addr;
    logic [BLOCK_W-1:0] lat_wdata;
    logic [BLOCK_W-1:0] i_rdata, d_rdata;

    assign i_pend   = bus.I_READ;
    assign d_pend   = bus.D_READ | bus.D_WRITE;
    assign any_pend = i_pend | d_pend;
    // On a tie the port that did not win last time goes next.
    assign winner   = (i_pend && d_pend) ? ~last_grant : d_pend;
    assign granted  = (state == ST_GRANT_I) || (state == ST_GRANT_D);
    // The entry cycle never completes: memory has not yet seen the request.
    assign done     = granted && !first_cycle && !bus.MEM_BUSYWAIT;

    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (any_pend) state_nxt = (winner == PORT_D) ? ST_GRANT_D : ST_GRANT_I;
            ST_GRANT_I,
            ST_GRANT_D: if (done) state_nxt = ST_RELEASE;
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            last_grant  <= PORT_D;
            first_cycle <= 1'b0;
            lat_read    <= 1'b0;
            lat_write   <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            i_rdata     <= '0;
            d_rdata     <= '0;
        end else begin
            first_cycle <= 1'b0;
            if (state == ST_IDLE && any_pend) begin
                last_grant  <= winner;
                first_cycle <= 1'b1;
                if (winner == PORT_D) begin
                    // Simultaneous read+write from D is serviced as the write alone.
                    lat_read  <= bus.D_READ & ~bus.D_WRITE;
                    lat_write <= bus.D_WRITE;
                    lat_addr  <= bus.D_ADDRESS;
                    lat_wdata <= bus.D_WRITEDATA;
                end else begin
                    lat_read  <= 1'b1;
                    lat_write <= 1'b0;
                    lat_addr  <= bus.I_ADDRESS;
                    lat_wdata <= '0;
                end
            end
            // Data for a requester that withdrew mid-grant is dropped.
            if (done && lat_read) begin
                if (state == ST_GRANT_I && bus.I_READ)
                    i_rdata <= bus.MEM_READDATA;
                if (state == ST_GRANT_D && bus.D_READ && !bus.D_WRITE)
                    d_rdata <= bus.MEM_READDATA;
            end
        end
    end

    always_comb begin
        bus.MEM_READ      = 1'b0;
        bus.MEM_WRITE     = 1'b0;
        bus.MEM_ADDRESS   = '0;
        bus.MEM_WRITEDATA = '0;
        if (granted) begin
            bus.MEM_READ      = lat_read;
            bus.MEM_WRITE     = lat_write;
            bus.MEM_ADDRESS   = lat_addr;
            bus.MEM_WRITEDATA = lat_wdata;
        end
        bus.I_BUSYWAIT = i_pend && !(state == ST_RELEASE && last_grant == PORT_I);
        bus.D_BUSYWAIT = d_pend && !(state == ST_RELEASE && last_grant == PORT_D);
        bus.I_READDATA = i_rdata;
        bus.D_READDATA = d_rdata;
    end

endmodule
